mac_multi_port_ctrl: RTL

- Parametrised memory access controller, successor to the single-core MAC state machine.
- Arbitrates NUM_CORES DLX control units onto one external AS_N/WR_N/ACK_N bus.
- Adds round-robin arbitration, atomic bus locking, an ACK timeout with error report, and per-core stall (stop_n) generation.
- Sits between the per-core DLX control FSMs and the shared memory bus in the dual/multi-core top.

---
 rtl/mac_multi_port_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mac_multi_port_ctrl.sv
// Multi-core memory access controller: round-robin arbitration of NUM_CORES
// requesters onto one AS_N/WR_N/ACK_N bus, with atomic locking and ACK timeout.
module mac_multi_port_ctrl #(
   parameter int NUM_CORES = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 255,
   parameter int TO_W      = 8,
   parameter int ID_W      = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        mr,
   input  logic [NUM_CORES-1:0]        mw,
   input  logic [NUM_CORES-1:0]        atomic,
   input  logic [NUM_CORES*ADDR_W-1:0] addr_in,
   input  logic [NUM_CORES*DATA_W-1:0] wdata_in,
   input  logic                        ACK_N,
   input  logic [DATA_W-1:0]           DIN,
   output logic                        AS_N,
   output logic                        WR_N,
   output logic [ADDR_W-1:0]           ADDR,
   output logic [DATA_W-1:0]           DOUT,
   output logic [DATA_W-1:0]           rdata,
   output logic [NUM_CORES-1:0]        done,
   output logic [NUM_CORES-1:0]        err,
   output logic [NUM_CORES-1:0]        stop_n,
   output logic                        busy,
   output logic [ID_W-1:0]             grant_id,
   output logic                        locked,
   output logic [1:0]                  MAC_STATE_OUT
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_WAIT = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;
   localparam logic [1:0] S_ERR  = 2'b11;

   localparam logic [ID_W:0]   NC_W     = (ID_W+1)'(NUM_CORES);
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_CORES-1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT-1);

   logic [1:0]           state_q, state_d;
   logic                 as_n_q, as_n_d, wr_n_q, wr_n_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    dout_q, dout_d, rdata_q, rdata_d;
   logic [ID_W-1:0]      grant_q, grant_d, last_q, last_d;
   logic                 locked_q, locked_d;
   logic [TO_W-1:0]      cnt_q, cnt_d;

   logic [NUM_CORES-1:0] req, gid_oh;
   logic                 arb_found;
   logic [ID_W-1:0]      arb_idx;
   logic [ID_W:0]        cand;

   assign req    = mr | mw;
   assign gid_oh = NUM_CORES'(1) << grant_q;

   // While locked only the owner may win; otherwise search cyclically from last+1.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      if (locked_q) begin
         arb_found = req[grant_q];
         arb_idx   = grant_q;
      end else begin
         for (int k = 1; k <= NUM_CORES; k++) begin
            cand = {1'b0, last_q} + (ID_W+1)'(k);
            if (cand >= NC_W) cand = cand - NC_W;
            if (!arb_found && req[cand[ID_W-1:0]]) begin
               arb_found = 1'b1;
               arb_idx   = cand[ID_W-1:0];
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      as_n_d   = as_n_q;
      wr_n_d   = wr_n_q;
      addr_d   = addr_q;
      dout_d   = dout_q;
      rdata_d  = rdata_q;
      grant_d  = grant_q;
      last_d   = last_q;
      locked_d = locked_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (locked_q && !atomic[grant_q]) locked_d = 1'b0;
            if (arb_found) begin
               addr_d  = addr_in[arb_idx*ADDR_W +: ADDR_W];
               dout_d  = wdata_in[arb_idx*DATA_W +: DATA_W];
               wr_n_d  = ~mw[arb_idx];
               as_n_d  = 1'b0;
               grant_d = arb_idx;
               last_d  = arb_idx;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + TO_W'(1);
            // ACK takes priority over a timeout on the same cycle.
            if (!ACK_N) begin
               if (wr_n_q) rdata_d = DIN;
               as_n_d  = 1'b1;
               wr_n_d  = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == TO_LAST) begin
               as_n_d  = 1'b1;
               wr_n_d  = 1'b1;
               state_d = S_ERR;
            end
         end
         S_DONE: begin
            locked_d = atomic[grant_q];
            state_d  = S_IDLE;
         end
         default: begin
            locked_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         as_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         addr_q   <= '0;
         dout_q   <= '0;
         rdata_q  <= '0;
         grant_q  <= '0;
         last_q   <= LAST_RST;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         as_n_q   <= as_n_d;
         wr_n_q   <= wr_n_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         rdata_q  <= rdata_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
      end
   end

   assign AS_N          = as_n_q;
   assign WR_N          = wr_n_q;
   assign ADDR          = addr_q;
   assign DOUT          = dout_q;
   assign rdata         = rdata_q;
   assign grant_id      = grant_q;
   assign locked        = locked_q;
   assign MAC_STATE_OUT = state_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE) ? gid_oh : '0;
   assign err           = (state_q == S_ERR)  ? gid_oh : '0;
   assign stop_n        = ~req | done | err;

endmodule
